div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW ops.
//  Responder side of the EX-stage divide handshake: EX holds en + operands stable while stalled on !out_valid.
//  Produces an RV64-compliant 64-bit result, including the divide-by-zero and signed-overflow cases.
//  Computes S quotient bits per cycle; purely sequential, no multi-cycle combinational paths.
// PARAMETERS
//  XLEN             64  datapath width; only 64 is supported.
//  STEPS_PER_CYCLE  1   quotient bits resolved per clock; legal values 1, 2, 4 (must divide 32).
// PORTS
//  clock      in   1     single clock, rising edge.
//  reset_n    in   1     asynchronous, active-low reset.
//  flush      in   1     synchronous pipeline flush; aborts any op.
//  en         in   1     level request; op, in1, in2 and div_word must stay stable while en=1 and out_valid=0.
//  op         in   2     0=DIV 1=DIVU 2=REM 3=REMU.
//  div_word   in   1     1 = W-variant (32-bit operate, sign-extend result).
//  in1        in   64    dividend.
//  in2        in   64    divisor.
//  out        out  64    result; meaningful only while out_valid=1.
//  out_valid  out  1     result ready.
//  out_ready  in   1     consumer accepts the result this cycle.
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, out=0, out_valid=0, all internal registers 0.
//  FSM states: IDLE, BUSY, DONE. out_valid is 1 exactly when state==DONE (registered output).
//  IDLE: when en=1, latch the operands.
//   - W-variant: operands are the low 32 bits of in1/in2; signed ops sign-extend them, unsigned ops zero-extend.
//   - Signed ops register |a|, |b|, sign_q = sa^sb and sign_r = sa.
//   - If the divisor is 0 or the op is signed overflow, load the special result and go to DONE (1 edge).
//   - Otherwise clear the remainder and counter, load the dividend into the shift register, and go to BUSY.
//  BUSY: each cycle performs S shift/trial-subtract steps: r={r,q[msb]}; if r>=b then r-=b and qbit=1.
//   - Step count is N=64, or N=32 for div_word; the W-variant operates on 32-bit shift/compare.
//   - After N/S cycles go to DONE with the fixed-up result registered into out.
//  Fixup: if sign_q, negate the quotient; if sign_r, negate the remainder.
//   - REM/REMU select the remainder; DIV/DIVU select the quotient.
//   - W-variant: out = sign-extend of result[31:0] for all four W ops, unsigned ones included.
//  Latency: out_valid first high N/S+1 edges after the edge sampling en in IDLE (65 for S=1 at 64b, 33 for W).
//   Special cases take 1 edge.
//  Divide by zero: quotient = all ones (W: 0xFFFFFFFF sign-extended), remainder = dividend (W: sign-extended).
//  Signed overflow (-2^63 / -1, W: -2^31 / -1): quotient = dividend, remainder = 0.
//  DONE: hold out and out_valid until out_ready=1, then go to IDLE (out_valid=0 next cycle).
//   - out is held; it is not cleared after the handshake.
//   - en=1 in the cycle after the handshake is treated as a new op (back-to-back issue).
//   - No same-cycle restart from DONE.
//  Abort: en=0 in BUSY/DONE means go to IDLE, drop the result, out_valid=0 next edge.
//  flush=1: go to IDLE at the next edge, whatever the state or en, and clear out_valid; flush beats out_ready.
//  reset_n low mid-BUSY: immediate IDLE, out_valid=0; no op resumes after release.
//  Unsigned compare/subtract uses 65-bit width so no trial subtraction is lost.
// TESTING
//  1 DIV in1=100 in2=7 en held, out_ready=1 -> out=14 at edge 65, out_valid 1 cycle; REM -> 2.
//  2 DIV in1=-7 in2=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -> 0xFFFF_FFFF_FFFF_FFFF (-1).
//  3 DIVU in1=5 in2=0 -> 0xFFFF_FFFF_FFFF_FFFF after 1 edge; REMU -> 5; DIVW in2=0 -> all ones.
//  4 DIV 0x8000_0000_0000_0000 / -1 -> same value, REM -> 0.
//    DIVW in1=0x8000_0000 in2=-1 -> 0xFFFF_FFFF_8000_0000, REMW -> 0.
//  5 DIVUW in1=0xFFFF_FFFF in2=1 -> 0xFFFF_FFFF_FFFF_FFFF at edge 33.
//    Hold out_ready=0 for 5 cycles -> out and out_valid stable.
//  6 flush at BUSY cycle 10 -> out_valid never rises, a new DIV 9/3 then gives 3 at edge 65.
//    Drop reset_n mid-BUSY -> out_valid=0, out=0 immediately.
//    Back-to-back: handshake, then en with 8/2 next cycle -> 4.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for the RV64M divide/remainder ops,
// covering the W variants and the RISC-V divide-by-zero and signed-overflow results.
module div_iter #(
  parameter int XLEN            = 64,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            en,
  input  logic [1:0]      op,
  input  logic            div_word,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic [XLEN-1:0] out,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [6:0] LAST_CNT_D = 7'(64 / STEPS_PER_CYCLE - 1);
  localparam logic [6:0] LAST_CNT_W = 7'(32 / STEPS_PER_CYCLE - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN-1:0] out_q, out_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            is_rem_q, is_rem_d;
  logic            word_q, word_d;

  logic            is_signed, sign_a, sign_b, div_zero, overflow;
  logic            load, last_step;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, int_min, special_res;
  logic [XLEN-1:0] quo_step, rem_step, quo_raw, quo_fix, rem_fix, fixup_res;
  logic [XLEN:0]   r_sh, trial;

  function automatic logic [63:0] word_fix(input logic [63:0] v, input logic w);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  always_comb begin
    is_signed = ~op[0];
    a_ext     = div_word ? {{32{is_signed & in1[31]}}, in1[31:0]} : in1;
    b_ext     = div_word ? {{32{is_signed & in2[31]}}, in2[31:0]} : in2;
    sign_a    = is_signed & a_ext[63];
    sign_b    = is_signed & b_ext[63];
    abs_a     = sign_a ? -a_ext : a_ext;
    abs_b     = sign_b ? -b_ext : b_ext;
    int_min   = div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero  = (b_ext == '0);
    overflow  = is_signed && (a_ext == int_min) && (b_ext == '1);
    if (div_zero) special_res = op[1] ? a_ext : '1;
    else          special_res = op[1] ? '0 : a_ext;
    special_res = word_fix(special_res, div_word);
  end

  // Remainder stays below the divisor, so a 65-bit trial never loses the carry.
  always_comb begin
    quo_step = quo_q;
    rem_step = rem_q;
    r_sh     = '0;
    trial    = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      r_sh     = {rem_step, quo_step[63]};
      trial    = r_sh - {1'b0, div_q};
      quo_step = {quo_step[62:0], ~trial[64]};
      rem_step = trial[64] ? r_sh[63:0] : trial[63:0];
    end
  end

  always_comb begin
    quo_raw   = word_q ? {32'b0, quo_step[31:0]} : quo_step;
    quo_fix   = neg_quo_q ? -quo_raw : quo_raw;
    rem_fix   = neg_rem_q ? -rem_step : rem_step;
    fixup_res = word_fix(is_rem_q ? rem_fix : quo_fix, word_q);
  end

  assign last_step = (cnt_q == (word_q ? LAST_CNT_W : LAST_CNT_D));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en && !flush) state_d = (div_zero || overflow) ? DONE : BUSY;
      BUSY: begin
        if (flush || !en)   state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE: if (flush || !en || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // W ops park the 32-bit dividend in the upper half so the same msb feeds the shifter.
  always_comb begin
    load      = (state_q == IDLE) && en && !flush;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    word_d    = word_q;
    if (load) begin
      quo_d     = div_word ? {abs_a[31:0], 32'b0} : abs_a;
      rem_d     = '0;
      div_d     = abs_b;
      cnt_d     = '0;
      neg_quo_d = sign_a ^ sign_b;
      neg_rem_d = sign_a;
      is_rem_d  = op[1];
      word_d    = div_word;
      if (div_zero || overflow) out_d = special_res;
    end else if ((state_q == BUSY) && en && !flush) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q + 7'd1;
      if (last_step) out_d = fixup_res;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      word_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      word_q    <= word_d;
    end
  end

  always_comb begin
    out       = out_q;
    out_valid = (state_q == DONE);
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter against an arithmetic
// reference of the RV64M divide/remainder rules.
module tb_div_iter;

  logic        clock = 1'b0;
  logic        reset_n, flush, en, div_word, out_valid, out_ready;
  logic [1:0]  op;
  logic [63:0] in1, in2, out;
  int          nChecks = 0;
  int          nErrors = 0;

  div_iter #(.XLEN(64), .STEPS_PER_CYCLE(1)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .en(en), .op(op),
    .div_word(div_word), .in1(in1), .in2(in2), .out(out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  // Op codes: 0=DIV 1=DIVU 2=REM 3=REMU
  function automatic logic [63:0] refResult(input logic [1:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic        isSigned, isRem;
    logic [63:0] q, r, sel;
    int          a32, b32;
    longint      a64, b64;
    isSigned = !o[0];
    isRem    = o[1];
    if (w) begin
      a32 = int'(a[31:0]);
      b32 = int'(b[31:0]);
      if (b[31:0] == 32'd0) begin
        q = 64'hFFFF_FFFF;
        r = 64'(a[31:0]);
      end else if (isSigned && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q = 64'(a[31:0]);
        r = 64'd0;
      end else if (isSigned) begin
        q = 64'(a32 / b32);
        r = 64'(a32 % b32);
      end else begin
        q = 64'(a[31:0] / b[31:0]);
        r = 64'(a[31:0] % b[31:0]);
      end
      sel = isRem ? r : q;
      return {{32{sel[31]}}, sel[31:0]};
    end
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (isSigned && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a;
      r = 64'd0;
    end else if (isSigned) begin
      a64 = a;
      b64 = b;
      q   = a64 / b64;
      r   = a64 % b64;
    end else begin
      q = a / b;
      r = a % b;
    end
    return isRem ? r : q;
  endfunction

  function automatic int refLatency(input logic [1:0] o, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    logic special;
    if (w) special = (b[31:0] == 32'd0) ||
                     (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   special = (b == 64'd0) || (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    return special ? 1 : (w ? 33 : 65);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic w, input logic [63:0] a,
                               input logic [63:0] b, input logic rdy);
    op        = o;
    div_word  = w;
    in1       = a;
    in2       = b;
    out_ready = rdy;
    en        = 1'b1;
  endtask

  // Counts edges from the request until out_valid, bounded so a dead DUT cannot hang us.
  task automatic waitValid(output int edges);
    edges = 0;
    do begin
      @(posedge clock);
      #1;
      edges++;
    end while (!out_valid && edges < 200);
  endtask

  task automatic finishOp(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    en = 1'b0;
    checkOutput({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] expected);
    int edges;
    applyStimulus(o, w, a, b, 1'b1);
    waitValid(edges);
    checkOutput({tag, "_lat"}, 64'(edges), 64'(refLatency(o, w, a, b)));
    checkOutput({tag, "_out"}, out, expected);
    finishOp(tag);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          edges;
    int          seen;
    logic [1:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;

    reset_n = 1'b1; flush = 1'b0; en = 1'b0; op = 2'd0; div_word = 1'b0;
    in1 = '0; in2 = '0; out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #10;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out", out, 64'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;

    runOp("div_100_7", 2'd0, 1'b0, 64'd100, 64'd7, 64'd14);
    runOp("rem_100_7", 2'd2, 1'b0, 64'd100, 64'd7, 64'd2);
    runOp("div_m7_2", 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("rem_m7_2", 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("divu_by0", 2'd1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("remu_by0", 2'd3, 1'b0, 64'd5, 64'd0, 64'd5);
    runOp("divw_by0", 2'd0, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("div_ovf", 2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
    runOp("rem_ovf", 2'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0);
    runOp("divw_ovf", 2'd0, 1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000);
    runOp("remw_ovf", 2'd2, 1'b1, 64'h8000_0000, '1, 64'd0);

    // Result must sit still while the consumer stalls.
    applyStimulus(2'd1, 1'b1, 64'hFFFF_FFFF, 64'd1, 1'b0);
    waitValid(edges);
    checkOutput("hold_lat", 64'(edges), 64'd33);
    checkOutput("hold_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (5) begin
      @(posedge clock);
      #1;
      checkOutput("hold_vld", 64'(out_valid), 64'd1);
      checkOutput("hold_stable", out, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    finishOp("hold");

    // Flush with en still high restarts from scratch on the following edge.
    applyStimulus(2'd0, 1'b0, 64'd100, 64'd7, 1'b1);
    repeat (10) @(posedge clock);
    #1;
    flush = 1'b1;
    in1   = 64'd9;
    in2   = 64'd3;
    @(posedge clock);
    #1;
    flush = 1'b0;
    checkOutput("flush_vld", 64'(out_valid), 64'd0);
    waitValid(edges);
    checkOutput("flush_lat", 64'(edges), 64'd65);
    checkOutput("flush_out", out, 64'd3);
    finishOp("flush");

    applyStimulus(2'd0, 1'b0, 64'd100, 64'd7, 1'b1);
    repeat (20) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstbusy_vld", 64'(out_valid), 64'd0);
    checkOutput("rstbusy_out", out, 64'd0);
    en = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    seen = 0;
    repeat (70) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1;
    end
    checkOutput("rstbusy_noresume", 64'(seen), 64'd0);

    applyStimulus(2'd0, 1'b0, 64'd100, 64'd7, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    en = 1'b0;
    seen = 0;
    repeat (70) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1;
    end
    checkOutput("abort_novalid", 64'(seen), 64'd0);

    // Back-to-back: new operands presented right after the handshake edge.
    applyStimulus(2'd0, 1'b0, 64'd100, 64'd7, 1'b1);
    waitValid(edges);
    checkOutput("b2b_first", out, 64'd14);
    @(posedge clock);
    #1;
    checkOutput("b2b_vld_drop", 64'(out_valid), 64'd0);
    in1 = 64'd8;
    in2 = 64'd2;
    waitValid(edges);
    checkOutput("b2b_lat", 64'(edges), 64'd65);
    checkOutput("b2b_out", out, 64'd4);
    finishOp("b2b");

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 1000));
      case ($urandom_range(0, 4))
        0:       rb = 64'($urandom_range(0, 15));
        1:       rb = 64'd0 - 64'($urandom_range(1, 9));
        2:       rb = {$urandom, $urandom};
        3:       rb = 64'($urandom);
        default: rb = ra >> $urandom_range(1, 40);
      endcase
      runOp($sformatf("rnd%0d", i), ro, rw, ra, rb, refResult(ro, rw, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
